// File: rtl/cp0_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : cp0_pkg
// Brief   : CP0 register numbering, Status/Cause layouts and ExcCode values
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package cp0_pkg;

  localparam logic [4:0] c_reg_badvaddr = 5'd8;
  localparam logic [4:0] c_reg_count    = 5'd9;
  localparam logic [4:0] c_reg_compare  = 5'd11;
  localparam logic [4:0] c_reg_status   = 5'd12;
  localparam logic [4:0] c_reg_cause    = 5'd13;
  localparam logic [4:0] c_reg_epc      = 5'd14;
  localparam logic [4:0] c_reg_ebase    = 5'd15;

  localparam logic [2:0] c_sel_0        = 3'd0;
  localparam logic [2:0] c_sel_ebase    = 3'd1;

  typedef struct packed {
    logic [8:0] zero_31_23;
    logic       bev;
    logic [5:0] zero_21_16;
    logic [7:0] im;
    logic [5:0] zero_7_2;
    logic       exl;
    logic       ie;
  } status_t;

  typedef struct packed {
    logic       bd;
    logic       ti;
    logic [5:0] zero_29_24;
    logic       iv;
    logic [6:0] zero_22_16;
    logic [7:0] ip;
    logic       zero_7;
    logic [4:0] exc_code;
    logic [1:0] zero_1_0;
  } cause_t;

  localparam logic [31:0] c_status_wmask = 32'h0040_FF03;
  localparam logic [31:0] c_cause_wmask  = 32'h0080_0300;
  localparam logic [31:0] c_ebase_wmask  = 32'h3FFF_F000;
  localparam logic [31:0] c_status_reset = 32'h0040_0000;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_MOD  = 5'd1,
    EXC_TLBL = 5'd2,
    EXC_TLBS = 5'd3,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_CPU  = 5'd11,
    EXC_OV   = 5'd12,
    EXC_TR   = 5'd13
  } exc_code_e;

endpackage
`default_nettype wire

// File: rtl/cp0_regfile_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : cp0_regfile_if
// Brief   : MTC0/MFC0 port, exception-unit commit port and CP0 state feedback
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface cp0_regfile_if;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [2:0]  cp0_sel;
  logic [31:0] mtc0_wdata;
  logic [31:0] mfc0_rdata;
  logic        exc_we;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_bd;
  logic        badvaddr_we;
  logic [31:0] badvaddr_in;
  logic        clear_exl;
  logic [5:0]  hw_int;
  logic [31:0] epc_out;
  logic        status_bev;
  logic        status_exl;
  logic        cause_iv;
  logic [31:0] ebase_out;
  logic        allow_int;
  logic [7:0]  int_pending;
  logic        timer_int;

  modport slave (
    input  mtc0_we, cp0_addr, cp0_sel, mtc0_wdata,
    input  exc_we, exc_code, exc_epc, exc_bd, badvaddr_we, badvaddr_in,
    input  clear_exl, hw_int,
    output mfc0_rdata, epc_out, status_bev, status_exl, cause_iv,
    output ebase_out, allow_int, int_pending, timer_int
  );

  modport master (
    output mtc0_we, cp0_addr, cp0_sel, mtc0_wdata,
    output exc_we, exc_code, exc_epc, exc_bd, badvaddr_we, badvaddr_in,
    output clear_exl, hw_int,
    input  mfc0_rdata, epc_out, status_bev, status_exl, cause_iv,
    input  ebase_out, allow_int, int_pending, timer_int
  );
endinterface
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : cp0_timer
// Brief   : Count/Compare timer with prescaler and sticky TI flag
//           (TI generation only when CP0_TIMER_INT_EN is defined)
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        div_q, div_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        inc;

  always_comb begin
    inc       = (div_q == 1'(COUNT_DIV - 1)) && !count_we;
    div_d     = div_q;
    count_d   = count_q;
    compare_d = compare_q;
    if (count_we) begin
      count_d = wdata;
      div_d   = 1'b0;
    end else if (inc) begin
      count_d = count_q + 32'd1;
      div_d   = 1'b0;
    end else begin
      div_d   = div_q + 1'b1;
    end
    if (compare_we) begin
      compare_d = wdata;
    end
    // A Compare write clears TI even when the match fires on the same edge
`ifdef CP0_TIMER_INT_EN
    ti_d = compare_we ? 1'b0 : (ti_q || (inc && (count_q == compare_q)));
`else
    ti_d = ti_q && !compare_we;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q     <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule
`default_nettype wire

// File: rtl/cp0_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : cp0_regfile
// Brief   : CP0 Status/Cause/EPC/BadVAddr/EBase plus Count/Compare timer;
//           CP0_TIMER_INT_EN routes the timer interrupt onto IP7/timer_int
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module cp0_regfile #(
  parameter int          COUNT_DIV   = 2,
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          resetn,
  cp0_regfile_if.slave  bus
);
  import cp0_pkg::*;

  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc, wr_ebase;
  status_t     status_q, status_d;
  logic        cause_bd_q, cause_bd_d;
  logic        cause_iv_q, cause_iv_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [5:0]  ip_hw_q;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [17:0] ebase_q, ebase_d;
  logic [31:0] count, compare;
  logic        ti, ip7;
  cause_t      cause_w;
  logic [31:0] ebase_w;
  logic [31:0] rdata;

  always_comb begin
    wr_count   = bus.mtc0_we && bus.cp0_addr == c_reg_count   && bus.cp0_sel == c_sel_0;
    wr_compare = bus.mtc0_we && bus.cp0_addr == c_reg_compare && bus.cp0_sel == c_sel_0;
    wr_status  = bus.mtc0_we && bus.cp0_addr == c_reg_status  && bus.cp0_sel == c_sel_0;
    wr_cause   = bus.mtc0_we && bus.cp0_addr == c_reg_cause   && bus.cp0_sel == c_sel_0;
    wr_epc     = bus.mtc0_we && bus.cp0_addr == c_reg_epc     && bus.cp0_sel == c_sel_0;
    wr_ebase   = bus.mtc0_we && bus.cp0_addr == c_reg_ebase   && bus.cp0_sel == c_sel_ebase;
  end

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (bus.mtc0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_comb begin
    status_d   = status_q;
    cause_bd_d = cause_bd_q;
    cause_iv_d = cause_iv_q;
    ip_sw_d    = ip_sw_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ebase_d    = ebase_q;

    if (wr_status) begin
      status_d = status_t'(bus.mtc0_wdata & c_status_wmask);
    end
    if (wr_cause) begin
      cause_iv_d = bus.mtc0_wdata[23];
      ip_sw_d    = bus.mtc0_wdata[9:8];
    end
    if (wr_ebase) begin
      ebase_d = bus.mtc0_wdata[29:12];
    end
    if (bus.badvaddr_we) begin
      badvaddr_d = bus.badvaddr_in;
    end

    // Exception/ERET commits own EXL, EPC, BD and ExcCode over any MTC0
    if (bus.exc_we) begin
      status_d.exl = 1'b1;
      exc_code_d   = bus.exc_code;
      if (!status_q.exl) begin
        epc_d      = bus.exc_epc;
        cause_bd_d = bus.exc_bd;
      end
    end else if (bus.clear_exl) begin
      status_d.exl = 1'b0;
    end else if (wr_epc) begin
      epc_d = bus.mtc0_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q   <= status_t'(c_status_reset);
      cause_bd_q <= 1'b0;
      cause_iv_q <= 1'b0;
      ip_sw_q    <= 2'b00;
      ip_hw_q    <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      ebase_q    <= EBASE_RESET[29:12];
    end else begin
      status_q   <= status_d;
      cause_bd_q <= cause_bd_d;
      cause_iv_q <= cause_iv_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= bus.hw_int;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      ebase_q    <= ebase_d;
    end
  end

`ifdef CP0_TIMER_INT_EN
  assign ip7           = ip_hw_q[5] | ti;
  assign bus.timer_int = ti;
`else
  assign ip7           = ip_hw_q[5];
  assign bus.timer_int = 1'b0;
`endif

  always_comb begin
    cause_w          = '0;
    cause_w.bd       = cause_bd_q;
    cause_w.ti       = ti;
    cause_w.iv       = cause_iv_q;
    cause_w.ip       = {ip7, ip_hw_q[4:0], ip_sw_q};
    cause_w.exc_code = exc_code_q;
  end

  assign ebase_w = {2'b10, ebase_q, 12'd0};

  always_comb begin
    rdata = 32'd0;
    case ({bus.cp0_addr, bus.cp0_sel})
      {c_reg_badvaddr, c_sel_0}:     rdata = badvaddr_q;
      {c_reg_count,    c_sel_0}:     rdata = count;
      {c_reg_compare,  c_sel_0}:     rdata = compare;
      {c_reg_status,   c_sel_0}:     rdata = status_q;
      {c_reg_cause,    c_sel_0}:     rdata = cause_w;
      {c_reg_epc,      c_sel_0}:     rdata = epc_q;
      {c_reg_ebase,    c_sel_ebase}: rdata = ebase_w;
      default:                       rdata = 32'd0;
    endcase
  end

  assign bus.mfc0_rdata  = rdata;
  assign bus.epc_out     = epc_q;
  assign bus.status_bev  = status_q.bev;
  assign bus.status_exl  = status_q.exl;
  assign bus.cause_iv    = cause_iv_q;
  assign bus.ebase_out   = ebase_w;
  assign bus.allow_int   = status_q.ie & ~status_q.exl;
  assign bus.int_pending = cause_w.ip & status_q.im;

endmodule
`default_nettype wire

// File: tb/tb_cp0_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_cp0_regfile
// Brief   : Directed stimulus for cp0_regfile with a per-cycle reference model
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_cp0_regfile;

  localparam int COUNT_DIV = 2;
`ifdef CP0_TIMER_INT_EN
  localparam bit TI_EN = 1'b1;
`else
  localparam bit TI_EN = 1'b0;
`endif
  localparam logic [31:0] TI_BITS = TI_EN ? 32'h4000_8000 : 32'h0;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;

  always #10 clk = ~clk;

  cp0_regfile_if bus ();

  cp0_regfile #(
    .COUNT_DIV   (COUNT_DIV),
    .EBASE_RESET (32'h8000_0000)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Reference state, kept as plain architectural values
  logic [31:0] m_status, m_epc, m_bad, m_count, m_compare, m_ebase;
  logic        m_bd, m_ti, m_iv;
  logic [1:0]  m_ip_sw;
  logic [5:0]  m_hw;
  logic [4:0]  m_code;
  int          m_phase;

  function automatic logic [7:0] m_ip();
    logic ip7;
    ip7 = m_hw[5] | (TI_EN & m_ti);
    return {ip7, m_hw[4:0], m_ip_sw};
  endfunction

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_iv) << 23) |
           (32'(m_ip()) << 8) | (32'(m_code) << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (s == 3'd0 && a == 5'd8)  return m_bad;
    if (s == 3'd0 && a == 5'd9)  return m_count;
    if (s == 3'd0 && a == 5'd11) return m_compare;
    if (s == 3'd0 && a == 5'd12) return m_status;
    if (s == 3'd0 && a == 5'd13) return m_cause();
    if (s == 3'd0 && a == 5'd14) return m_epc;
    if (s == 3'd1 && a == 5'd15) return m_ebase;
    return 32'd0;
  endfunction

  function automatic bit wr(input int a, input int s);
    return bus.mtc0_we && int'(bus.cp0_addr) == a && int'(bus.cp0_sel) == s;
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0000; m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0;
    m_ebase = 32'h8000_0000; m_bd = 0; m_ti = 0; m_iv = 0; m_ip_sw = 0;
    m_hw = 0; m_code = 0; m_phase = 0;
  endtask

  task automatic model_step();
    bit old_exl;
    bit tick_now;
    old_exl  = m_status[1];
    tick_now = (m_phase == COUNT_DIV - 1);
    if (wr(9, 0)) begin
      m_count = bus.mtc0_wdata;
      m_phase = 0;
    end else begin
      if (tick_now) begin
        if (TI_EN && m_count == m_compare) m_ti = 1'b1;
        m_count = m_count + 1;
      end
      m_phase = (m_phase + 1) % COUNT_DIV;
    end
    if (wr(11, 0)) begin
      m_compare = bus.mtc0_wdata;
      m_ti = 1'b0;
    end
    if (wr(12, 0)) m_status = bus.mtc0_wdata & 32'h0040_FF03;
    if (bus.exc_we) m_status[1] = 1'b1;
    else if (bus.clear_exl) m_status[1] = 1'b0;
    if (bus.exc_we) begin
      m_code = bus.exc_code;
      if (!old_exl) begin
        m_epc = bus.exc_epc;
        m_bd  = bus.exc_bd;
      end
    end else if (wr(14, 0) && !bus.clear_exl) begin
      m_epc = bus.mtc0_wdata;
    end
    if (wr(13, 0)) begin
      m_iv    = bus.mtc0_wdata[23];
      m_ip_sw = bus.mtc0_wdata[9:8];
    end
    if (wr(15, 1)) m_ebase = 32'h8000_0000 | (bus.mtc0_wdata & 32'h3FFF_F000);
    if (bus.badvaddr_we) m_bad = bus.badvaddr_in;
    m_hw = bus.hw_int;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) model_reset();
    else         model_step();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("mfc0_rdata",  bus.mfc0_rdata, m_read(bus.cp0_addr, bus.cp0_sel));
      check("epc_out",     bus.epc_out, m_epc);
      check("status_bev",  32'(bus.status_bev), 32'(m_status[22]));
      check("status_exl",  32'(bus.status_exl), 32'(m_status[1]));
      check("cause_iv",    32'(bus.cause_iv), 32'(m_iv));
      check("ebase_out",   bus.ebase_out, m_ebase);
      check("allow_int",   32'(bus.allow_int), 32'(m_status[0] & ~m_status[1]));
      check("int_pending", 32'(bus.int_pending), 32'(m_ip() & m_status[15:8]));
      check("timer_int",   32'(bus.timer_int), 32'(TI_EN & m_ti));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.mtc0_we = 0; bus.exc_we = 0; bus.clear_exl = 0; bus.badvaddr_we = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
    bus.mtc0_we = 1; bus.cp0_addr = a; bus.cp0_sel = s; bus.mtc0_wdata = d;
    step();
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] epc, input logic bd);
    bus.exc_we = 1; bus.exc_code = code; bus.exc_epc = epc; bus.exc_bd = bd;
    step();
  endtask

  task automatic rd(input string n, input logic [4:0] a, input logic [2:0] s,
                    input logic [31:0] e);
    bus.cp0_addr = a; bus.cp0_sel = s;
    #1;
    check(n, bus.mfc0_rdata, e);
  endtask

  initial begin
    resetn = 1'b1;
    bus.mtc0_we = 0; bus.cp0_addr = 0; bus.cp0_sel = 0; bus.mtc0_wdata = 0;
    bus.exc_we = 0; bus.exc_code = 0; bus.exc_epc = 0; bus.exc_bd = 0;
    bus.badvaddr_we = 0; bus.badvaddr_in = 0; bus.clear_exl = 0; bus.hw_int = 0;
    #1 resetn = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    rd("rst_status", 5'd12, 3'd0, 32'h0040_0000);
    rd("rst_unimpl", 5'd1, 3'd0, 32'h0);
    check("rst_ebase", bus.ebase_out, 32'h8000_0000);
    check("rst_allow", 32'(bus.allow_int), 32'h0);
    check("rst_pend", 32'(bus.int_pending), 32'h0);
    check("rst_bev", 32'(bus.status_bev), 32'h1);

    bus.hw_int = 6'b000001;
    mtc0(5'd12, 3'd0, 32'h0000_FF01);
    check("ie_allow", 32'(bus.allow_int), 32'h1);
    check("ie_pend", 32'(bus.int_pending), 32'h04);

    exc(5'd0, 32'h8000_1004, 1'b1);
    check("exc_exl", 32'(bus.status_exl), 32'h1);
    check("exc_allow", 32'(bus.allow_int), 32'h0);
    check("exc_epc", bus.epc_out, 32'h8000_1004);
    rd("exc_cause", 5'd13, 3'd0, 32'h8000_0400 | TI_BITS);
    exc(5'd12, 32'h0000_1234, 1'b0);
    check("nested_epc", bus.epc_out, 32'h8000_1004);
    rd("nested_cause", 5'd13, 3'd0, 32'h8000_0430 | TI_BITS);
    bus.clear_exl = 1;
    step();
    check("eret_exl", 32'(bus.status_exl), 32'h0);
    check("eret_allow", 32'(bus.allow_int), 32'h1);

    // Count write edge is edge 0; with COUNT_DIV=2 the match on 5 fires at edge 12
    mtc0(5'd11, 3'd0, 32'd5);
    mtc0(5'd9, 3'd0, 32'd0);
    bus.cp0_addr = 5'd9;
    step();
    step();
    rd("count_after2", 5'd9, 3'd0, 32'd1);
    for (int k = 3; k <= 11; k++) step();
    check("ti_before", 32'(bus.timer_int), 32'h0);
    step();
    check("ti_set", 32'(bus.timer_int), 32'(TI_EN));
    check("ti_pend", 32'(bus.int_pending), TI_EN ? 32'h84 : 32'h04);
    rd("count_at12", 5'd9, 3'd0, 32'd6);
    mtc0(5'd11, 3'd0, 32'd100);
    check("ti_clear", 32'(bus.timer_int), 32'h0);
    rd("compare_rd", 5'd11, 3'd0, 32'd100);

    bus.mtc0_we = 1; bus.cp0_addr = 5'd14; bus.cp0_sel = 0; bus.mtc0_wdata = 32'hAAAA;
    bus.exc_we = 1; bus.exc_code = 5'd4; bus.exc_epc = 32'hBBBB; bus.exc_bd = 0;
    step();
    check("conflict_epc", bus.epc_out, 32'hBBBB);
    bus.mtc0_we = 1; bus.cp0_addr = 5'd14; bus.mtc0_wdata = 32'h5555; bus.clear_exl = 1;
    step();
    check("eret_epc_hold", bus.epc_out, 32'hBBBB);
    bus.mtc0_we = 1; bus.cp0_addr = 5'd12; bus.mtc0_wdata = 32'h0000_FF00;
    bus.exc_we = 1; bus.exc_code = 5'd8; bus.exc_epc = 32'hCCCC;
    step();
    rd("conflict_status", 5'd12, 3'd0, 32'h0000_FF02);
    check("conflict_epc2", bus.epc_out, 32'hCCCC);
    bus.mtc0_we = 1; bus.cp0_addr = 5'd12; bus.mtc0_wdata = 32'h0000_FF01; bus.clear_exl = 1;
    step();
    rd("eret_status", 5'd12, 3'd0, 32'h0000_FF01);

    mtc0(5'd12, 3'd0, 32'hFFFF_FFFF);
    rd("status_mask", 5'd12, 3'd0, 32'h0040_FF03);
    mtc0(5'd12, 3'd0, 32'h0000_FF01);
    mtc0(5'd15, 3'd1, 32'hFFFF_FFFF);
    check("ebase_wr", bus.ebase_out, 32'hBFFF_F000);
    mtc0(5'd1, 3'd0, 32'hFFFF_FFFF);
    rd("unimpl_wr", 5'd1, 3'd0, 32'h0);
    rd("ebase_sel0", 5'd15, 3'd0, 32'h0);
    mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
    check("iv_wr", 32'(bus.cause_iv), 32'h1);
    check("ipsw_pend", 32'(bus.int_pending), 32'h07);
    mtc0(5'd8, 3'd0, 32'h1234);
    rd("badv_ro", 5'd8, 3'd0, 32'h0);
    bus.badvaddr_we = 1; bus.badvaddr_in = 32'hDEAD_BEEF;
    step();
    rd("badv_we", 5'd8, 3'd0, 32'hDEAD_BEEF);
    bus.hw_int = 6'b100001;
    step();
    check("hw5_pend", 32'(bus.int_pending), 32'h87);
    bus.hw_int = 6'b000001;

    exc(5'd0, 32'h40, 1'b0);
    mtc0(5'd11, 3'd0, 32'd3);
    mtc0(5'd9, 3'd0, 32'd3);
    step();
    step();
    check("ti_pre_rst", 32'(bus.timer_int), 32'(TI_EN));
    step();
    #1 resetn = 1'b0;
    #1;
    check("arst_exl", 32'(bus.status_exl), 32'h0);
    check("arst_ti", 32'(bus.timer_int), 32'h0);
    check("arst_epc", bus.epc_out, 32'h0);
    check("arst_ebase", bus.ebase_out, 32'h8000_0000);
    check("arst_pend", 32'(bus.int_pending), 32'h0);
    rd("arst_status", 5'd12, 3'd0, 32'h0040_0000);
    rd("arst_count", 5'd9, 3'd0, 32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
